// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-cycle-latency fetch from a combinational ROM
// with valid/ready output, redirect from execute and halt from decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_cnt,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_inst_r;
  logic [31:0] fetch_cnt_r;
  logic        out_valid_r;
  logic        halted_r;
  logic        load_s;
  logic        accept_s;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Output-slot handshake terms
  always_comb begin
    load_s   = !out_valid_r || out_ready;
    accept_s = out_valid_r && out_ready;
  end

  // Fetch FSM, pc, output slot and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_PC;
      out_valid_r <= 1'b0;
      out_pc_r    <= 32'h0000_0000;
      out_inst_r  <= 32'h0000_0000;
      fetch_cnt_r <= 32'h0000_0000;
      halted_r    <= 1'b0;
    end else begin
      // The handshake still counts on the cycle a redirect or halt squashes the slot
      if (accept_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            state_r     <= ST_HALT;
            out_valid_r <= 1'b0;
            halted_r    <= 1'b1;
          end else if (redirect_valid) begin
            pc_r        <= align_word(redirect_pc);
            out_valid_r <= 1'b0;
          end else if (load_s) begin
            out_pc_r    <= pc_r;
            out_inst_r  <= inst_data;
            out_valid_r <= 1'b1;
            pc_r        <= pc_r + 32'd4;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_BOOT;
          out_valid_r <= 1'b0;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  assign inst_addr = pc_r;
  assign out_valid = out_valid_r;
  assign out_pc    = out_pc_r;
  assign out_inst  = out_inst_r;
  assign fetch_cnt = fetch_cnt_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a reference stream of expected fetch
// addresses is refilled/flushed by the stimulus and drained by a monitor.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_cnt;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tail_pc = RESET_PC;
  logic        halted_m = 1'b0;
  logic        boot_m = 1'b0;
  logic [31:0] model_cnt = 32'd0;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .inst_data(inst_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .fetch_cnt(fetch_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign inst_data = rom(inst_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(tail_pc);
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  // Advance one clock: apply the reference effect of the inputs consumed at
  // this edge, then drive the next cycle's inputs.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic h);
    @(posedge clk);
    if (boot_m) begin
      boot_m = 1'b0;
    end else if (!halted_m) begin
      if (halt) begin
        halted_m = 1'b1;
      end else if (redirect_valid) begin
        exp_q.delete();
        tail_pc = redirect_pc & ~32'd3;
      end
    end
    refill();
    #1;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_inst_addr", inst_addr, RESET_PC);
    exp_q.delete();
    halted_m       = 1'b0;
    boot_m         = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tail_pc = RESET_PC;
    refill();
    rst_n  = 1'b1;
    boot_m = 1'b1;
  endtask

  // Release cycle and BOOT cycle: nothing presented, fetch address at reset PC
  task automatic boot_start();
    chk("boot0_valid", {31'd0, out_valid}, 32'd0);
    chk("boot0_addr", inst_addr, RESET_PC);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("boot1_valid", {31'd0, out_valid}, 32'd0);
    chk("boot1_addr", inst_addr, RESET_PC);
  endtask

  // Monitor: pops the reference stream on every handshake
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_cnt = 32'd0;
      end else begin
        chk("fetch_cnt", fetch_cnt, model_cnt);
        chk("halted", {31'd0, halted}, {31'd0, halted_m});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual_pc=%h expected=none", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e);
            chk("out_inst", out_inst, rom(e));
          end
          model_cnt = model_cnt + 32'd1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    boot_start();
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, RESET_PC);

    // Backpressure for three edges while 0x8000_0004 is presented
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("bp_pc0", out_pc, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      step(i == 2 ? 1'b1 : 1'b0, 1'b0, 32'd0, 1'b0);
      chk("bp_hold_pc", out_pc, 32'h8000_0004);
      chk("bp_hold_inst", out_inst, rom(32'h8000_0004));
      chk("bp_hold_addr", inst_addr, 32'h8000_0008);
    end
    step(1'b1, 1'b1, 32'h8000_0103, 1'b0);
    chk("bp_release_pc", out_pc, 32'h8000_0008);

    // Redirect with misaligned target, then redirect to the wrap boundary
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", inst_addr, 32'h8000_0100);
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("redir_pc", out_pc, 32'h8000_0100);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("wrap_addr", inst_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("wrap_pc1", out_pc, 32'h0000_0000);

    // Random ready and redirects against the reference stream
    repeat (300) begin
      step(($urandom % 10) < 7, ($urandom % 20) == 0, $urandom, 1'b0);
    end

    // Mid-stream reset with an instruction pending
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    boot_start();

    // Halt and redirect together; later redirect/ready ignored
    step(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    chk("pre_halt_pc", out_pc, RESET_PC);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_addr", inst_addr, 32'h8000_0004);
    repeat (10) begin
      step($urandom % 2 == 0, 1'b1, $urandom, 1'b0);
      chk("halt_hold_addr", inst_addr, 32'h8000_0004);
      chk("halt_hold_valid", {31'd0, out_valid}, 32'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
